lap_recorder: RTL and testbench

LAP_RECORDER -- requirements
Module: lap_recorder

---
 rtl/lap_recorder.sv | 119 +++++++++++
 tb/tb_lap_recorder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lap_recorder.sv
// rtl/lap_recorder.sv - stopwatch lap memory with live/review display selection
//
// Stores up to DEPTH lap times as 16-bit words {min, st, su, ten}, in arrival
// order with slot 0 as the oldest. A two-state machine (LIVE/REVIEW) chooses
// whether the display sees the live digits or a stored lap.
//
// Ports:
//   clock                  rising-edge system clock
//   reset                  synchronous active-high reset
//   lap_pulse              one-cycle capture request (only while running)
//   recall_pulse           one-cycle review step request
//   clear_pulse            one-cycle clear request, beats lap/recall
//   running                stopwatch running flag
//   live_min/st/su/ten     live BCD digits
//   out_min/st/su/ten      registered digits to the display mux
//   showing_lap            1 while a stored lap is on out_*
//   lap_index              slot being reviewed (0 = oldest)
//   lap_count              number of valid stored laps
//   full                   lap_count == DEPTH
//   overflow               sticky: a lap was dropped because storage was full
module lap_recorder #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lap_pulse,
  input  logic       recall_pulse,
  input  logic       clear_pulse,
  input  logic       running,
  input  logic [3:0] live_min,
  input  logic [3:0] live_st,
  input  logic [3:0] live_su,
  input  logic [3:0] live_ten,
  output logic [3:0] out_min,
  output logic [3:0] out_st,
  output logic [3:0] out_su,
  output logic [3:0] out_ten,
  output logic       showing_lap,
  output logic [2:0] lap_index,
  output logic [3:0] lap_count,
  output logic       full,
  output logic       overflow
);

  localparam logic ST_LIVE   = 1'b0;
  localparam logic ST_REVIEW = 1'b1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  logic        state;
  // Sized for the largest legal DEPTH so the 3-bit slot index always fits;
  // only the first DEPTH entries are ever written.
  logic [15:0] slots [8];
  logic [15:0] live_word;
  logic [15:0] out_word;
  logic        lap_req;
  logic        capture_ok;
  logic        last_lap;

  assign live_word  = {live_min, live_st, live_su, live_ten};
  assign lap_req    = lap_pulse && running;
  assign capture_ok = lap_req && (lap_count < DEPTH_L);
  // Uses lap_count before any same-cycle capture lands.
  assign last_lap   = ({1'b0, lap_index} == (lap_count - 4'd1));
  assign full       = (lap_count == DEPTH_L);

  always_ff @(posedge clock) begin
    if (reset || clear_pulse) begin
      state     <= ST_LIVE;
      lap_count <= 4'd0;
      lap_index <= 3'd0;
      overflow  <= 1'b0;
    end else begin
      if (capture_ok) begin
        lap_count <= lap_count + 4'd1;
      end else if (lap_req) begin
        overflow <= 1'b1;
      end

      if (recall_pulse) begin
        if (state == ST_LIVE) begin
          if (lap_count != 4'd0) begin
            state     <= ST_REVIEW;
            lap_index <= 3'd0;
          end
        end else if (last_lap) begin
          state     <= ST_LIVE;
          lap_index <= 3'd0;
        end else begin
          lap_index <= lap_index + 3'd1;
        end
      end
    end
  end

  // Slot contents survive reset and clear; lap_count alone defines validity.
  always_ff @(posedge clock) begin
    if (!reset && !clear_pulse && capture_ok) begin
      slots[lap_count[2:0]] <= live_word;
    end
  end

  // Display stage follows the registered state, so a new review slot appears
  // one cycle after the state/index change and showing_lap stays aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_word    <= 16'h0000;
      showing_lap <= 1'b0;
    end else begin
      showing_lap <= (state == ST_REVIEW);
      out_word    <= (state == ST_REVIEW) ? slots[lap_index] : live_word;
    end
  end

  assign out_min = out_word[15:12];
  assign out_st  = out_word[11:8];
  assign out_su  = out_word[7:4];
  assign out_ten = out_word[3:0];

endmodule

// File: tb/tb_lap_recorder.sv
// tb/tb_lap_recorder.sv - directed scoreboard bench for lap_recorder
module tb_lap_recorder;

  logic       clock = 1'b0;
  logic       reset;
  logic       lap_pulse, recall_pulse, clear_pulse, running;
  logic [3:0] live_min, live_st, live_su, live_ten;
  logic [3:0] out_min, out_st, out_su, out_ten;
  logic       showing_lap;
  logic [2:0] lap_index;
  logic [3:0] lap_count;
  logic       full, overflow;

  localparam int F_OUT = 0, F_SHOW = 1, F_IDX = 2, F_CNT = 3, F_FULL = 4, F_OVF = 5;

  typedef struct {
    string       tag;
    int          f;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  lap_recorder #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .lap_pulse(lap_pulse), .recall_pulse(recall_pulse), .clear_pulse(clear_pulse),
    .running(running),
    .live_min(live_min), .live_st(live_st), .live_su(live_su), .live_ten(live_ten),
    .out_min(out_min), .out_st(out_st), .out_su(out_su), .out_ten(out_ten),
    .showing_lap(showing_lap), .lap_index(lap_index), .lap_count(lap_count),
    .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] actual(input int f);
    case (f)
      F_OUT:   return {out_min, out_st, out_su, out_ten};
      F_SHOW:  return {15'd0, showing_lap};
      F_IDX:   return {13'd0, lap_index};
      F_CNT:   return {12'd0, lap_count};
      F_FULL:  return {15'd0, full};
      default: return {15'd0, overflow};
    endcase
  endfunction

  task automatic ex(input string tag, input int f, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.f = f; e.v = v;
    sb.push_back(e);
  endtask

  task automatic set_live(input logic [15:0] w);
    {live_min, live_st, live_su, live_ten} = w;
  endtask

  task automatic check_all();
    exp_t e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = actual(e.f);
      total++;
      assert (got === e.v)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, got, e.v);
      end
    end
  endtask

  task automatic cyc(input logic l, input logic r, input logic c);
    lap_pulse = l; recall_pulse = r; clear_pulse = c;
    @(posedge clock);
    #1;
    lap_pulse = 1'b0; recall_pulse = 1'b0; clear_pulse = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; running = 1'b1;
    lap_pulse = 1'b0; recall_pulse = 1'b0; clear_pulse = 1'b0;
    set_live(16'h9999);

    // reset beats pulses
    ex("rst_out", F_OUT, 16'h0000); ex("rst_show", F_SHOW, 0); ex("rst_idx", F_IDX, 0);
    ex("rst_cnt", F_CNT, 0); ex("rst_full", F_FULL, 0); ex("rst_ovf", F_OVF, 0);
    cyc(1, 1, 0);
    reset = 1'b0;

    // live passthrough, latency 1
    running = 1'b0; set_live(16'h1234);
    ex("pass_out", F_OUT, 16'h1234); ex("pass_show", F_SHOW, 0);
    cyc(0, 0, 0);

    // three captures
    running = 1'b1;
    set_live(16'h0051); ex("cap1_cnt", F_CNT, 1); ex("cap1_out", F_OUT, 16'h0051); cyc(1, 0, 0);
    set_live(16'h0127); ex("cap2_cnt", F_CNT, 2); cyc(1, 0, 0);
    set_live(16'h0200); ex("cap3_cnt", F_CNT, 3); ex("cap3_full", F_FULL, 0); cyc(1, 0, 0);
    set_live(16'h1234);

    // review walk
    ex("rv1_idx", F_IDX, 0); ex("rv1_out", F_OUT, 16'h1234); ex("rv1_show", F_SHOW, 0); cyc(0, 1, 0);
    ex("rv2_idx", F_IDX, 1); ex("rv2_out", F_OUT, 16'h0051); ex("rv2_show", F_SHOW, 1); cyc(0, 1, 0);
    ex("rv3_idx", F_IDX, 2); ex("rv3_out", F_OUT, 16'h0127); ex("rv3_show", F_SHOW, 1); cyc(0, 1, 0);
    ex("rv4_idx", F_IDX, 0); ex("rv4_out", F_OUT, 16'h0200); ex("rv4_cnt", F_CNT, 3); cyc(0, 1, 0);
    ex("rv5_out", F_OUT, 16'h1234); ex("rv5_show", F_SHOW, 0); cyc(0, 0, 0);

    // lap ignored while stopped
    running = 1'b0; ex("ign_cnt", F_CNT, 3); cyc(1, 0, 0);

    // fill and overflow
    running = 1'b1;
    set_live(16'h0300); ex("fill_cnt", F_CNT, 4); ex("fill_full", F_FULL, 1); ex("fill_ovf", F_OVF, 0); cyc(1, 0, 0);
    set_live(16'h0400); ex("ovf_cnt", F_CNT, 4); ex("ovf_full", F_FULL, 1); ex("ovf_ovf", F_OVF, 1); cyc(1, 0, 0);
    set_live(16'h1234);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    ex("full_idx3", F_IDX, 3); ex("full_out2", F_OUT, 16'h0200); cyc(0, 1, 0);
    ex("slot3_out", F_OUT, 16'h0300); ex("slot3_show", F_SHOW, 1); cyc(0, 0, 0);
    ex("wrap4_idx", F_IDX, 0); ex("wrap4_ovf", F_OVF, 1); cyc(0, 1, 0);
    ex("wrap4_show", F_SHOW, 0); ex("wrap4_out", F_OUT, 16'h1234); cyc(0, 0, 0);

    // clear, then empty recall
    ex("clr_cnt", F_CNT, 0); ex("clr_ovf", F_OVF, 0); ex("clr_full", F_FULL, 0); cyc(0, 0, 1);
    ex("erec_idx", F_IDX, 0); cyc(0, 1, 0);
    ex("erec_show", F_SHOW, 0); cyc(0, 0, 0);

    // lap + recall from LIVE with no laps
    set_live(16'h0009); ex("lr_cnt", F_CNT, 1); ex("lr_idx", F_IDX, 0); cyc(1, 1, 0);
    ex("lr_show", F_SHOW, 0); ex("lr_out", F_OUT, 16'h0009); cyc(0, 0, 0);

    // clear + lap + recall from REVIEW with two laps
    set_live(16'h0010); ex("s2_cnt", F_CNT, 2); cyc(1, 0, 0);
    cyc(0, 1, 0);
    ex("s2_idx", F_IDX, 1); ex("s2_show", F_SHOW, 1); cyc(0, 1, 0);
    ex("clp_cnt", F_CNT, 0); ex("clp_idx", F_IDX, 0); ex("clp_ovf", F_OVF, 0); cyc(1, 1, 1);
    ex("clp_show", F_SHOW, 0); cyc(0, 0, 0);

    // capture during review, then reset mid-review
    set_live(16'h0500); cyc(1, 0, 0);
    set_live(16'h0600); cyc(1, 0, 0);
    ex("mr_idx0", F_IDX, 0); cyc(0, 1, 0);
    set_live(16'h0700);
    ex("mr_cnt", F_CNT, 3); ex("mr_idx1", F_IDX, 1); ex("mr_out", F_OUT, 16'h0500); cyc(1, 1, 0);
    reset = 1'b1;
    ex("mrst_out", F_OUT, 16'h0000); ex("mrst_show", F_SHOW, 0); ex("mrst_idx", F_IDX, 0);
    ex("mrst_cnt", F_CNT, 0); ex("mrst_ovf", F_OVF, 0); cyc(1, 1, 0);
    reset = 1'b0;
    ex("post_out", F_OUT, 16'h0700); ex("post_show", F_SHOW, 0); cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
